// File: rtl/aes_pkg.sv
// aes_pkg: shared AES block/state types, S-box table and GF(2^8) helpers
// imported by the round engine, its interface and the single-round datapath
package aes_pkg;

   typedef logic [0:127] aes_block_t;

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      DONE
   } aes_state_e;

   // forward S-box, byte x at bits [8x : 8x+7]
   localparam logic [0:2047] SBOX = {
      256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
      256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
      256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
      256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
      256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
      256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
      256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
      256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] gmul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

   // round count for a key length; 0 flags an illegal length
   function automatic int nr_of(input int key_bits);
      if (key_bits == 128) return 10;
      else if (key_bits == 192) return 12;
      else if (key_bits == 256) return 14;
      else return 0;
   endfunction

endpackage

// File: rtl/aes_round_engine_if.sv
// aes_round_engine_if: block-in / ciphertext-out handshake bundle
// master = producer/consumer side, slave = engine side
interface aes_round_engine_if
   import aes_pkg::*;
#(
   parameter int KEY_BITS = 128
);
   localparam int SCHED_W = 128 * (nr_of(KEY_BITS) + 1);

   logic                 in_valid;
   logic                 in_ready;
   aes_block_t           in_data;
   logic [0:SCHED_W-1]   in_sched;
   logic                 out_valid;
   logic                 out_ready;
   aes_block_t           out_data;
   logic                 busy;

   modport master (
      output in_valid, in_data, in_sched, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, in_sched, out_ready,
      output in_ready, out_valid, out_data, busy
   );

endinterface

// File: rtl/aes_round.sv
// aes_round: one combinational AES encryption round
// final_rnd bypasses MixColumns for the last round
module aes_round
   import aes_pkg::*;
(
   input  aes_block_t state_in,
   input  aes_block_t rkey,
   input  logic       final_rnd,
   output aes_block_t state_out
);

   aes_block_t sb;
   aes_block_t sr;
   aes_block_t mc;
   logic [7:0] a0, a1, a2, a3;

   // SubBytes, ShiftRows and MixColumns on the column-major state
   always_comb begin
      sb = '0;
      sr = '0;
      mc = '0;
      a0 = '0;
      a1 = '0;
      a2 = '0;
      a3 = '0;
      for (int i = 0; i < 16; i++)
         sb[8*i +: 8] = sbox(state_in[8*i +: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[8*(4*c+r) +: 8] = sb[8*(4*((c+r)%4)+r) +: 8];
      for (int c = 0; c < 4; c++) begin
         a0 = sr[32*c    +: 8];
         a1 = sr[32*c+8  +: 8];
         a2 = sr[32*c+16 +: 8];
         a3 = sr[32*c+24 +: 8];
         mc[32*c    +: 8] = gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3;
         mc[32*c+8  +: 8] = a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3;
         mc[32*c+16 +: 8] = a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3);
         mc[32*c+24 +: 8] = gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3);
      end
   end

   assign state_out = (final_rnd ? sr : mc) ^ rkey;

endmodule

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encryption core, one round per clock
// owns the FSM, round counter and the key schedule captured at accept
module aes_round_engine
   import aes_pkg::*;
#(
   parameter int KEY_BITS = 128
) (
   input logic               clk,
   input logic               rst,
   aes_round_engine_if.slave bus
);

   localparam int NR      = nr_of(KEY_BITS);
   localparam int SCHED_W = 128 * (NR + 1);

   if (NR == 0) begin : g_bad_key
      $error("aes_round_engine: KEY_BITS must be 128, 192 or 256");
   end

   aes_state_e         state_q, state_d;
   logic [3:0]         rcnt_q, rcnt_d;
   aes_block_t         data_q, data_d;
   logic [0:SCHED_W-1] sched_q, sched_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   aes_block_t rkey;
   aes_block_t rnd_out;
   logic       in_ready;
   logic       accept;
   logic       final_rnd;

   // a finished block may drain and a new one load in the same cycle
   assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
   assign accept    = bus.in_valid & in_ready;
   assign final_rnd = (rcnt_q == 4'(NR));
   assign rkey      = sched_q[{rcnt_q, 7'd0} +: 128];

   aes_round u_round (
      .state_in  (data_q),
      .rkey      (rkey),
      .final_rnd (final_rnd),
      .state_out (rnd_out)
   );

   // next-state: load on accept, one round per cycle, hold until drained
   always_comb begin
      state_d     = state_q;
      rcnt_d      = rcnt_q;
      data_d      = data_q;
      sched_d     = sched_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = ROUND;
               rcnt_d  = 4'd1;
               sched_d = bus.in_sched;
               data_d  = bus.in_data ^ bus.in_sched[0:127];
            end
         end
         ROUND: begin
            data_d = rnd_out;
            if (final_rnd) begin
               out_valid_d = 1'b1;
               state_d     = DONE;
               rcnt_d      = 4'd0;
            end else begin
               rcnt_d = rcnt_q + 4'd1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
               if (accept) begin
                  state_d = ROUND;
                  rcnt_d  = 4'd1;
                  sched_d = bus.in_sched;
                  data_d  = bus.in_data ^ bus.in_sched[0:127];
               end
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // state registers with synchronous reset that aborts any block in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rcnt_q      <= '0;
         data_q      <= '0;
         sched_q     <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rcnt_q      <= rcnt_d;
         data_q      <= data_d;
         sched_q     <= sched_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = data_q;
   assign bus.busy      = busy_q;

endmodule
